// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: programmable divide-by-N output with start/stop sequencing and
// period-boundary divisor updates. Define DIV_PERIOD_CNT_EN to add period_cnt_o.
module clk_div_ctrl #(
    parameter int W           = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cfg_valid_i,
    output logic         cfg_ready_o,
    input  logic [W-1:0] cfg_div_i,
    input  logic         start_i,
    input  logic         stop_i,
    output logic         out_d_o,
    output logic         tick_o,
    output logic         busy_o,
    output logic [W-1:0] div_cur_o
`ifdef DIV_PERIOD_CNT_EN
    ,
    output logic [15:0]  period_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic logic [W-1:0] clamp_div(input logic [W-1:0] d);
        if (d < W'(2)) begin
            clamp_div = W'(2);
        end else begin
            clamp_div = d;
        end
    endfunction

    function automatic logic [W:0] half_ceil(input logic [W-1:0] n);
        half_ceil = ({1'b0, n} + {{W{1'b0}}, 1'b1}) >> 1;
    endfunction

    state_t       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] div_q, div_d;
    logic         pend_q, pend_d;
    logic [W-1:0] pval_q, pval_d;
    logic         out_q, out_d;
    logic         tick_q, tick_d;
    logic         busy_q, busy_d;
    logic         ready_q, ready_d;
    logic         xfer_s;
    logic         wrap_s;
    logic         go_s;

    assign xfer_s = cfg_valid_i && ready_q;
    assign wrap_s = (state_q != IDLE) && (cnt_q == div_q - W'(1));
    assign go_s   = (state_q == IDLE) && start_i && !stop_i;

    // Next-state, counter and divisor-update logic; outputs derive from the next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        pend_d  = pend_q;
        pval_d  = pval_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (xfer_s) begin
                    div_d = clamp_div(cfg_div_i);
                end else begin
                    div_d = div_q;
                end
                if (go_s) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN, DRAIN: begin
                if (wrap_s) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + W'(1);
                end
                // A value accepted on a wrap edge waits for the following wrap.
                if (wrap_s && pend_q) begin
                    div_d  = pval_q;
                    pend_d = 1'b0;
                end else begin
                    div_d  = div_q;
                end
                if (xfer_s) begin
                    pend_d = 1'b1;
                    pval_d = clamp_div(cfg_div_i);
                end else begin
                    pval_d = pval_q;
                end
                if (state_q == RUN) begin
                    if (stop_i) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = RUN;
                    end
                end else if (wrap_s) begin
                    state_d = IDLE;
                    if (pend_d) begin
                        div_d  = pval_d;
                        pend_d = 1'b0;
                    end else begin
                        div_d  = div_d;
                    end
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                pend_d  = 1'b0;
            end
        endcase
        busy_d  = (state_d != IDLE);
        tick_d  = busy_d && (cnt_d == '0);
        out_d   = busy_d && ({1'b0, cnt_d} < half_ceil(div_d));
        ready_d = (state_d == IDLE) || !pend_d;
    end

    // State and registered-output flops.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= W'(DEFAULT_DIV);
            pend_q  <= 1'b0;
            pval_q  <= W'(DEFAULT_DIV);
            out_q   <= 1'b0;
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            pend_q  <= pend_d;
            pval_q  <= pval_d;
            out_q   <= out_d;
            tick_q  <= tick_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign cfg_ready_o = ready_q;
    assign out_d_o     = out_q;
    assign tick_o      = tick_q;
    assign busy_o      = busy_q;
    assign div_cur_o   = div_q;

`ifdef DIV_PERIOD_CNT_EN
    logic [15:0] pcnt_q, pcnt_d;

    // Completed-period counter, restarted by each start.
    always_comb begin
        pcnt_d = pcnt_q;
        if (go_s) begin
            pcnt_d = 16'd0;
        end else if (wrap_s) begin
            pcnt_d = pcnt_q + 16'd1;
        end else begin
            pcnt_d = pcnt_q;
        end
    end

    // Period counter flop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pcnt_q <= 16'd0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    assign period_cnt_o = pcnt_q;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed scenarios plus a randomized run
// compared against a cycle-level behavioural model of the divider.
module tb_clk_div_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_div;
    logic         start;
    logic         stop;
    logic         out_d;
    logic         tick;
    logic         busy;
    logic [W-1:0] div_cur;
`ifdef DIV_PERIOD_CNT_EN
    logic [15:0]  period_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    // Model: mode 0 idle / 1 running / 2 draining, position within the period,
    // divisor in effect, and an optional pending divisor.
    int m_mode, m_pos, m_n, m_pend, m_pval, m_pc;

    clk_div_ctrl #(.W(W), .DEFAULT_DIV(2)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cfg_valid_i (cfg_valid),
        .cfg_ready_o (cfg_ready),
        .cfg_div_i   (cfg_div),
        .start_i     (start),
        .stop_i      (stop),
        .out_d_o     (out_d),
        .tick_o      (tick),
        .busy_o      (busy),
        .div_cur_o   (div_cur)
`ifdef DIV_PERIOD_CNT_EN
        ,
        .period_cnt_o(period_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic int clampi(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    function automatic bit e_busy();
        return m_mode != 0;
    endfunction
    function automatic bit e_tick();
        return (m_mode != 0) && (m_pos == 0);
    endfunction
    function automatic bit e_out();
        return (m_mode != 0) && (m_pos < (m_n + 1) / 2);
    endfunction
    function automatic bit e_ready();
        return (m_mode == 0) || (m_pend == 0);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_n = 2; m_pend = 0; m_pval = 0; m_pc = 0;
    endtask

    // Drive one cycle of inputs, advance the model over the edge, sample #1 later.
    task automatic step(input bit s, input bit p, input bit v, input int d);
        bit xfer;
        bit wrap;
        start = s; stop = p; cfg_valid = v; cfg_div = d[W-1:0];
        xfer = v && e_ready();
        if (m_mode == 0) begin
            if (xfer) m_n = clampi(d);
            if (s && !p) begin m_mode = 1; m_pos = 0; m_pc = 0; end
        end else begin
            wrap = (m_pos == m_n - 1);
            m_pos = wrap ? 0 : m_pos + 1;
            if (wrap) m_pc = (m_pc + 1) % 65536;
            if (wrap && m_pend != 0) begin m_n = m_pval; m_pend = 0; end
            if (xfer) begin m_pend = 1; m_pval = clampi(d); end
            if (m_mode == 1 && p) m_mode = 2;
            else if (m_mode == 2 && wrap) begin
                m_mode = 0; m_pos = 0;
                if (m_pend != 0) begin m_n = m_pval; m_pend = 0; end
            end
        end
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
    endtask

    task automatic drain_to_idle();
        int guard;
        guard = 0;
        step(1'b0, 1'b1, 1'b0, 0);
        while (m_mode != 0 && guard < 300) begin
            step(1'b0, 1'b0, 1'b0, 0);
            guard++;
        end
    endtask

    // Steps until the DUT shows a tick; returns the number of cycles taken.
    task automatic cycles_to_tick(output int n);
        n = 0;
        do begin
            step(1'b0, 1'b0, 1'b0, 0);
            n++;
        end while (!tick && n < 64);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        model_reset();
        #12;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (out_d !== 1'b0) begin failures++; $display("FAIL reset_out got=%b exp=0", out_d); end
        checks++; if (tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", tick); end
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cfg_ready); end
        checks++; if (div_cur !== 8'd2) begin failures++; $display("FAIL reset_div got=%0d exp=2", div_cur); end
        @(negedge clk); rst = 1'b0;
        step(1'b0, 1'b1, 1'b0, 0);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stop_in_idle got=%b exp=0", busy); end
    endtask

    task automatic test_div2();
        bit exp_pat[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        step(1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_d !== exp_pat[i]) begin failures++; $display("FAIL div2_out[%0d] got=%b exp=%b", i, out_d, exp_pat[i]); end
            checks++; if (tick !== exp_pat[i]) begin failures++; $display("FAIL div2_tick[%0d] got=%b exp=%b", i, tick, exp_pat[i]); end
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL div2_busy[%0d] got=%b exp=1", i, busy); end
            step(1'b0, 1'b0, 1'b0, 0);
        end
        drain_to_idle();
    endtask

    task automatic test_cfg_idle();
        step(1'b0, 1'b0, 1'b1, 5);
        checks++; if (div_cur !== 8'd5) begin failures++; $display("FAIL idle_cfg_div got=%0d exp=5", div_cur); end
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL idle_cfg_ready got=%b exp=1", cfg_ready); end
        step(1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 10; i++) begin
            checks++; if (out_d !== ((i % 5) < 3)) begin failures++; $display("FAIL div5_out[%0d] got=%b exp=%b", i, out_d, (i % 5) < 3); end
            checks++; if (tick !== ((i % 5) == 0)) begin failures++; $display("FAIL div5_tick[%0d] got=%b exp=%b", i, tick, (i % 5) == 0); end
            step(1'b0, 1'b0, 1'b0, 0);
        end
        drain_to_idle();
    endtask

    task automatic test_cfg_run();
        int n;
        step(1'b0, 1'b0, 1'b1, 4);
        step(1'b1, 1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 1'b1, 6);
        checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL run_cfg_ready_low got=%b exp=0", cfg_ready); end
        checks++; if (div_cur !== 8'd4) begin failures++; $display("FAIL run_cfg_div_old got=%0d exp=4", div_cur); end
        step(1'b0, 1'b0, 1'b0, 0);
        checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL run_cfg_ready_hold got=%b exp=0", cfg_ready); end
        step(1'b0, 1'b0, 1'b0, 0);
        checks++; if (div_cur !== 8'd6) begin failures++; $display("FAIL run_cfg_div_new got=%0d exp=6", div_cur); end
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL run_cfg_ready_back got=%b exp=1", cfg_ready); end
        cycles_to_tick(n);
        checks++; if (n != 6) begin failures++; $display("FAIL run_cfg_period got=%0d exp=6", n); end
        drain_to_idle();
    endtask

    task automatic test_cfg_at_wrap();
        int n;
        step(1'b0, 1'b0, 1'b1, 3);
        step(1'b1, 1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 1'b1, 8);
        checks++; if (tick !== 1'b1) begin failures++; $display("FAIL wrap_xfer_tick got=%b exp=1", tick); end
        checks++; if (div_cur !== 8'd3) begin failures++; $display("FAIL wrap_xfer_div_old got=%0d exp=3", div_cur); end
        cycles_to_tick(n);
        checks++; if (n != 3) begin failures++; $display("FAIL wrap_xfer_period1 got=%0d exp=3", n); end
        cycles_to_tick(n);
        checks++; if (n != 8) begin failures++; $display("FAIL wrap_xfer_period2 got=%0d exp=8", n); end
        drain_to_idle();
    endtask

    task automatic test_stop();
        step(1'b0, 1'b0, 1'b1, 4);
        step(1'b1, 1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 1'b0, 0);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL stop_drain1 got=%b exp=1", busy); end
        step(1'b1, 1'b0, 1'b0, 0);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL stop_drain2 got=%b exp=1", busy); end
        step(1'b0, 1'b0, 1'b0, 0);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stop_idle_busy got=%b exp=0", busy); end
        checks++; if (out_d !== 1'b0) begin failures++; $display("FAIL stop_idle_out got=%b exp=0", out_d); end
        step(1'b1, 1'b1, 1'b0, 0);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL start_stop_idle got=%b exp=0", busy); end
    endtask

    task automatic test_async_reset();
        step(1'b0, 1'b0, 1'b1, 7);
        step(1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 0);
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL async_rst_busy got=%b exp=0", busy); end
        checks++; if (out_d !== 1'b0) begin failures++; $display("FAIL async_rst_out got=%b exp=0", out_d); end
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL async_rst_ready got=%b exp=1", cfg_ready); end
        checks++; if (div_cur !== 8'd2) begin failures++; $display("FAIL async_rst_div got=%0d exp=2", div_cur); end
        model_reset();
        @(negedge clk); rst = 1'b0;
        step(1'b0, 1'b0, 1'b1, 9);
        step(1'b0, 1'b0, 1'b1, 0);
        checks++; if (div_cur !== 8'd2) begin failures++; $display("FAIL clamp0 got=%0d exp=2", div_cur); end
        step(1'b0, 1'b0, 1'b1, 9);
        step(1'b0, 1'b0, 1'b1, 1);
        checks++; if (div_cur !== 8'd2) begin failures++; $display("FAIL clamp1 got=%0d exp=2", div_cur); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(7, 0) == 0, $urandom_range(15, 0) == 0,
                 $urandom_range(2, 0) == 0, int'($urandom_range(12, 0)));
            checks++; if (out_d !== e_out()) begin failures++; $display("FAIL rnd_out[%0d] got=%b exp=%b", i, out_d, e_out()); end
            checks++; if (tick !== e_tick()) begin failures++; $display("FAIL rnd_tick[%0d] got=%b exp=%b", i, tick, e_tick()); end
            checks++; if (busy !== e_busy()) begin failures++; $display("FAIL rnd_busy[%0d] got=%b exp=%b", i, busy, e_busy()); end
            checks++; if (cfg_ready !== e_ready()) begin failures++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", i, cfg_ready, e_ready()); end
            checks++; if (div_cur !== m_n[W-1:0]) begin failures++; $display("FAIL rnd_div[%0d] got=%0d exp=%0d", i, div_cur, m_n); end
`ifdef DIV_PERIOD_CNT_EN
            checks++; if (period_cnt !== m_pc[15:0]) begin failures++; $display("FAIL rnd_pcnt[%0d] got=%0d exp=%0d", i, period_cnt, m_pc); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_div2();
        test_cfg_idle();
        test_cfg_run();
        test_cfg_at_wrap();
        test_stop();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
